player_motion: RTL and testbench
================================

// Module: player_motion
// PURPOSE
//   Per-frame player position controller feeding player_x/player_y to the VGA pixel generator.
//   Samples walk/jump buttons once per frame, during vertical blank.
//   Moves the sprite horizontally with screen-edge clamping.
//   Runs a GROUND/RISE/FALL jump state machine so the sprite never leaves the playfield.
// PARAMETERS
//   SPRITE_WIDTH   32   sprite width, pixels
//   X_MIN          144  leftmost legal player_x (first visible hCount)
//   X_MAX          784  first hCount past visible area; player_x <= X_MAX-SPRITE_WIDTH
//   X_START        300  player_x after reset
//   GROUND_Y       362  player_y when standing (ground line 394 minus sprite height 32)
//   WALK_STEP      2    horizontal pixels moved per frame tick
//   JUMP_STEP      4    vertical pixels moved per frame tick while airborne
//   JUMP_FRAMES    16   frame ticks spent in RISE; peak y = GROUND_Y-JUMP_STEP*JUMP_FRAMES
//   FRAME_LINE     490  vCount value whose first appearance generates the frame tick
// PORTS
//   clk        in   1   pixel/system clock
//   rst        in   1   synchronous reset, active-high
//   vCount     in   10  current VGA line from the sync generator
//   btn_left   in   1   walk-left button, asynchronous
//   btn_right  in   1   walk-right button, asynchronous
//   btn_jump   in   1   jump button, asynchronous
//   player_x   out  10  sprite left edge, registered
//   player_y   out  10  sprite top edge, registered
//   jumping    out  1   1 while state is RISE or FALL
//   facing     out  1   0 = right, 1 = left; last walked direction
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//     player_x = X_START; player_y = GROUND_Y; state = GROUND; jumping = 0; facing = 0.
//     Jump counter = 0; jump_armed = 1; synchronizer flops = 0; vCount_d = 0.
//     A reset in mid-jump lands the sprite on the ground immediately.
//   Buttons:
//     Each button passes through a 2-flop synchronizer.
//     Only the synchronized values are used.
//   Frame tick:
//     tick = (vCount == FRAME_LINE) && (vCount_d != FRAME_LINE), where vCount_d is vCount delayed one cycle.
//     Exactly one tick per frame.
//     All state and outputs change only in the cycle after a tick; they hold otherwise.
//   Horizontal motion, per tick:
//     left only: if player_x < X_MIN+WALK_STEP then X_MIN, else player_x-WALK_STEP; facing = 1.
//     right only: if player_x+WALK_STEP > X_MAX-SPRITE_WIDTH then X_MAX-SPRITE_WIDTH, else +WALK_STEP; facing = 0.
//     Both or neither: x and facing hold.
//     Walking is allowed in every jump state.
//     Comparisons use 11-bit intermediates, so there is no 10-bit wrap.
//   Jump FSM, evaluated per tick:
//     jump_armed is set on any tick where sync jump = 0.
//     A held button therefore gives one jump; it must be released and pressed again.
//     GROUND: if jump = 1 and jump_armed: go to RISE, cnt = 0, jump_armed = 0.
//     RISE: player_y -= JUMP_STEP; cnt += 1; when cnt reaches JUMP_FRAMES-1 (this tick), go to FALL.
//     FALL: if player_y+JUMP_STEP >= GROUND_Y: player_y = GROUND_Y and go to GROUND; else player_y += JUMP_STEP.
//     A jump press while in RISE or FALL is ignored; it neither queues nor re-arms.
//     jumping = (state != GROUND), registered alongside player_y.
//   Illegal FSM encodings go to GROUND with player_y = GROUND_Y.
// TESTING
//   1. Reset, then 3 ticks with right held -> player_x = 306, facing = 0, player_y = 362, jumping = 0.
//   2. Left held for 100 ticks from X_START -> player_x decreases by 2 per tick and stops at 144, never wraps.
//   3. Right held for 300 ticks -> player_x saturates at 752; left+right together -> x holds.
//   4. Jump pulse at one tick -> y = 358 one cycle after the next tick, peak 298 after 16 ticks.
//      y back at 362 after 32 ticks; jumping = 1 throughout and 0 on landing.
//   5. Jump held continuously for 60 ticks -> exactly one jump;
//      release for 1 tick then press -> a second jump starts.
//   6. rst asserted at y = 318 during RISE -> next cycle x = 300, y = 362, jumping = 0.
//      vCount parked at 490 for many cycles -> only one tick.

Source files
------------

// File: rtl/player_motion.sv
// player_motion
//   Per-frame player position controller for the VGA sprite. The walk and
//   jump buttons are synchronized to clk_i and acted on once per frame. The
//   frame tick fires on the first cycle that vCount_i shows FRAME_LINE, which
//   falls in vertical blank. Horizontal motion is clamped to the visible
//   area. A GROUND/RISE/FALL state machine moves the sprite through a
//   symmetric jump arc and lands it exactly on the ground line.
//
// Ports
//   clk_i        in   1   pixel/system clock
//   rst_i        in   1   synchronous reset, active-high
//   vCount_i     in   10  current VGA line from the sync generator
//   btn_left_i   in   1   walk-left button, asynchronous
//   btn_right_i  in   1   walk-right button, asynchronous
//   btn_jump_i   in   1   jump button, asynchronous
//   player_x_o   out  10  sprite left edge, registered
//   player_y_o   out  10  sprite top edge, registered
//   jumping_o    out  1   1 while airborne (RISE or FALL)
//   facing_o     out  1   0 = right, 1 = left; last walked direction
module player_motion #(
  parameter int unsigned SPRITE_WIDTH = 32,
  parameter int unsigned X_MIN        = 144,
  parameter int unsigned X_MAX        = 784,
  parameter int unsigned X_START      = 300,
  parameter int unsigned GROUND_Y     = 362,
  parameter int unsigned WALK_STEP    = 2,
  parameter int unsigned JUMP_STEP    = 4,
  parameter int unsigned JUMP_FRAMES  = 16,
  parameter int unsigned FRAME_LINE   = 490
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] vCount_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_jump_i,
  output logic [9:0] player_x_o,
  output logic [9:0] player_y_o,
  output logic       jumping_o,
  output logic       facing_o
);

  localparam int unsigned CNT_W = $clog2(JUMP_FRAMES + 1);

  // Edge checks run one bit wider than the position so that stepping past
  // either screen edge can never wrap around and look legal.
  localparam logic [10:0] X_MIN_W   = 11'(X_MIN);
  localparam logic [10:0] X_RIGHT_W = 11'(X_MAX - SPRITE_WIDTH);
  localparam logic [10:0] WALK_W    = 11'(WALK_STEP);
  localparam logic [10:0] JUMP_W    = 11'(JUMP_STEP);
  localparam logic [10:0] GROUND_W  = 11'(GROUND_Y);

  localparam logic [9:0] X_MIN_V    = 10'(X_MIN);
  localparam logic [9:0] X_RIGHT_V  = 10'(X_MAX - SPRITE_WIDTH);
  localparam logic [9:0] X_START_V  = 10'(X_START);
  localparam logic [9:0] GROUND_V   = 10'(GROUND_Y);
  localparam logic [9:0] WALK_V     = 10'(WALK_STEP);
  localparam logic [9:0] JUMP_V     = 10'(JUMP_STEP);
  localparam logic [9:0] FRAME_V    = 10'(FRAME_LINE);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(JUMP_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_e;

  logic [2:0]       btnMeta_q;
  logic [2:0]       btnSync_q;
  logic [9:0]       vCountDly_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             facing_q, facing_d;
  logic             jumping_q, jumping_d;

  logic             tick;
  logic             leftSync, rightSync, jumpSync;
  logic [10:0]      xWide, yWide, xRight, yDown;

  // Two-flop synchronizers for the buttons (bit order {jump, right, left})
  // and the one-cycle delayed line count used for frame-tick detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btnMeta_q   <= 3'b000;
      btnSync_q   <= 3'b000;
      vCountDly_q <= 10'd0;
    end else begin
      btnMeta_q   <= {btn_jump_i, btn_right_i, btn_left_i};
      btnSync_q   <= btnMeta_q;
      vCountDly_q <= vCount_i;
    end
  end

  assign leftSync  = btnSync_q[0];
  assign rightSync = btnSync_q[1];
  assign jumpSync  = btnSync_q[2];

  // Only the first cycle of FRAME_LINE counts, however long vCount parks there.
  assign tick = (vCount_i == FRAME_V) && (vCountDly_q != FRAME_V);

  assign xWide  = {1'b0, x_q};
  assign yWide  = {1'b0, y_q};
  assign xRight = xWide + WALK_W;
  assign yDown  = yWide + JUMP_W;

  // Next-state logic for position, facing and the jump FSM. Everything holds
  // unless this is a frame-tick cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    x_d       = x_q;
    y_d       = y_q;
    facing_d  = facing_q;
    jumping_d = jumping_q;

    if (tick) begin
      if (leftSync && !rightSync) begin
        if (xWide < X_MIN_W + WALK_W) begin
          x_d = X_MIN_V;
        end else begin
          x_d = x_q - WALK_V;
        end
        facing_d = 1'b1;
      end else if (rightSync && !leftSync) begin
        if (xRight > X_RIGHT_W) begin
          x_d = X_RIGHT_V;
        end else begin
          x_d = x_q + WALK_V;
        end
        facing_d = 1'b0;
      end

      // A released button re-arms in any state; a press only launches from
      // the ground, so holding the button yields a single jump.
      if (!jumpSync) begin
        armed_d = 1'b1;
      end

      case (state_q)
        GROUND: begin
          if (jumpSync && armed_q) begin
            state_d = RISE;
            cnt_d   = '0;
            armed_d = 1'b0;
          end
        end
        RISE: begin
          y_d   = y_q - JUMP_V;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = FALL;
          end
        end
        FALL: begin
          if (yDown >= GROUND_W) begin
            y_d     = GROUND_V;
            state_d = GROUND;
          end else begin
            y_d = y_q + JUMP_V;
          end
        end
        default: begin
          state_d = GROUND;
          y_d     = GROUND_V;
        end
      endcase

      jumping_d = (state_d != GROUND);
    end
  end

  // Motion state registers; a reset mid-jump drops the sprite on the ground.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= GROUND;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      x_q       <= X_START_V;
      y_q       <= GROUND_V;
      facing_q  <= 1'b0;
      jumping_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      x_q       <= x_d;
      y_q       <= y_d;
      facing_q  <= facing_d;
      jumping_q <= jumping_d;
    end
  end

  assign player_x_o = x_q;
  assign player_y_o = y_q;
  assign jumping_o  = jumping_q;
  assign facing_o   = facing_q;

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion
//   Self-checking bench for player_motion. A behavioural model tracks the
//   sprite as plain integers (position, airborne flag, ticks since launch)
//   and a compare process checks every DUT output against it on every
//   falling clock edge once reset has been applied. Directed frames with
//   hand-computed expectations are followed by randomized frames.
module tb_player_motion;

  localparam int G_Y     = 362;
  localparam int X_LO    = 144;
  localparam int X_HI    = 752;
  localparam int X_RST   = 300;
  localparam int WALK    = 2;
  localparam int JSTEP   = 4;
  localparam int JFRAMES = 16;
  localparam int FLINE   = 490;

  logic       clk;
  logic       rst;
  logic [9:0] vCount;
  logic       btnLeft;
  logic       btnRight;
  logic       btnJump;
  logic [9:0] playerX;
  logic [9:0] playerY;
  logic       jumping;
  logic       facing;

  int comparisons = 0;
  int failures    = 0;
  bit checkEn     = 0;

  player_motion dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .vCount_i    (vCount),
    .btn_left_i  (btnLeft),
    .btn_right_i (btnRight),
    .btn_jump_i  (btnJump),
    .player_x_o  (playerX),
    .player_y_o  (playerY),
    .jumping_o   (jumping),
    .facing_o    (facing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int mX, mY, mFacing, mJumping, mAge, mPrevV;
  bit mAir, mArmed, mTick;
  bit [2:0] mHist0, mHist1;
  bit mL, mR, mJ;

  // Model update at each rising edge: buttons are seen two samples late,
  // a tick is the first cycle of FRAME_LINE, and the jump is an arc indexed
  // by the number of ticks since launch.
  always @(posedge clk) begin
    if (rst) begin
      mX = X_RST; mY = G_Y; mFacing = 0; mJumping = 0;
      mAir = 0; mAge = 0; mArmed = 1; mPrevV = 0;
      mHist0 = 3'b000; mHist1 = 3'b000;
    end else begin
      mL = mHist1[0]; mR = mHist1[1]; mJ = mHist1[2];
      mTick = (int'(vCount) == FLINE) && (mPrevV != FLINE);
      mPrevV = int'(vCount);
      if (mTick) begin
        if (mL && !mR) begin
          mX = (mX - WALK < X_LO) ? X_LO : mX - WALK;
          mFacing = 1;
        end else if (mR && !mL) begin
          mX = (mX + WALK > X_HI) ? X_HI : mX + WALK;
          mFacing = 0;
        end
        if (mAir) begin
          mAge++;
          if (mAge <= JFRAMES) mY = G_Y - JSTEP * mAge;
          else if (mY + JSTEP >= G_Y) begin mY = G_Y; mAir = 0; end
          else mY = G_Y - JSTEP * JFRAMES + JSTEP * (mAge - JFRAMES);
        end else if (mJ && mArmed) begin
          mAir = 1; mAge = 0; mArmed = 0;
        end
        if (!mJ) mArmed = 1;
        mJumping = mAir ? 1 : 0;
      end
      mHist1 = mHist0;
      mHist0 = {btnJump, btnRight, btnLeft};
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    comparisons++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_x", int'(playerX), mX);
      checkOutput("model_y", int'(playerY), mY);
      checkOutput("model_jumping", int'(jumping), mJumping);
      checkOutput("model_facing", int'(facing), mFacing);
    end
  end

  // One compressed frame: the tick lands on the first 490 cycle and the
  // task returns at the falling edge right after the tick edge.
  task automatic applyStimulus(input bit l, input bit r, input bit j, input int hold490);
    @(negedge clk); btnLeft = l; btnRight = r; btnJump = j; vCount = 10'd0;
    @(negedge clk); vCount = 10'd100;
    @(negedge clk); vCount = 10'd489;
    repeat (hold490) begin @(negedge clk); vCount = 10'd490; end
    @(negedge clk); vCount = 10'd491;
  endtask

  task automatic doReset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int v;
    rst = 1'b1; vCount = 10'd0;
    btnLeft = 1'b0; btnRight = 1'b0; btnJump = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkEn = 1;
    rst = 1'b0;
    checkOutput("reset_x", int'(playerX), 300);
    checkOutput("reset_y", int'(playerY), 362);
    checkOutput("reset_jumping", int'(jumping), 0);
    checkOutput("reset_facing", int'(facing), 0);

    $display("[TB] right walk");
    repeat (3) applyStimulus(0, 1, 0, 1);
    checkOutput("right3_x", int'(playerX), 306);
    checkOutput("right3_facing", int'(facing), 0);
    checkOutput("right3_y", int'(playerY), 362);

    $display("[TB] left clamp");
    doReset();
    repeat (10) applyStimulus(1, 0, 0, 1);
    checkOutput("left10_x", int'(playerX), 280);
    checkOutput("left10_facing", int'(facing), 1);
    repeat (90) applyStimulus(1, 0, 0, 1);
    checkOutput("left_clamp_x", int'(playerX), 144);

    $display("[TB] right clamp and both buttons");
    doReset();
    repeat (300) applyStimulus(0, 1, 0, 1);
    checkOutput("right_clamp_x", int'(playerX), 752);
    repeat (5) applyStimulus(1, 1, 0, 1);
    checkOutput("both_hold_x", int'(playerX), 752);
    checkOutput("both_hold_facing", int'(facing), 0);

    $display("[TB] single jump arc");
    applyStimulus(0, 0, 1, 1);
    checkOutput("launch_y", int'(playerY), 362);
    checkOutput("launch_jumping", int'(jumping), 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("rise1_y", int'(playerY), 358);
    repeat (15) applyStimulus(0, 0, 0, 1);
    checkOutput("peak_y", int'(playerY), 298);
    repeat (15) applyStimulus(0, 0, 0, 1);
    checkOutput("fall_last_y", int'(playerY), 358);
    checkOutput("fall_last_jumping", int'(jumping), 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("land_y", int'(playerY), 362);
    checkOutput("land_jumping", int'(jumping), 0);

    $display("[TB] held jump");
    applyStimulus(0, 0, 1, 1);
    checkOutput("held_launch_jumping", int'(jumping), 1);
    repeat (59) applyStimulus(0, 0, 1, 1);
    checkOutput("held_end_y", int'(playerY), 362);
    checkOutput("held_end_jumping", int'(jumping), 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("rearm_jumping", int'(jumping), 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("rearm_rise_y", int'(playerY), 358);
    repeat (31) applyStimulus(0, 0, 0, 1);
    checkOutput("rearm_land_jumping", int'(jumping), 0);

    $display("[TB] reset mid-jump and parked line");
    applyStimulus(0, 0, 1, 1);
    repeat (11) applyStimulus(0, 0, 0, 1);
    checkOutput("midjump_y", int'(playerY), 318);
    doReset();
    checkOutput("midjump_rst_x", int'(playerX), 300);
    checkOutput("midjump_rst_y", int'(playerY), 362);
    checkOutput("midjump_rst_jumping", int'(jumping), 0);
    applyStimulus(0, 1, 0, 50);
    checkOutput("parked_x", int'(playerX), 302);

    $display("[TB] randomized frames");
    for (int f = 0; f < 2000; f++) begin
      int lines;
      int hold;
      lines = int'($urandom_range(2, 6));
      hold  = int'($urandom_range(1, 4));
      for (int c = 0; c < lines + hold; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 5) == 0) btnLeft  = ~btnLeft;
        if ($urandom_range(0, 5) == 0) btnRight = ~btnRight;
        if ($urandom_range(0, 3) == 0) btnJump  = ~btnJump;
        rst = ($urandom_range(0, 599) == 0);
        if (c < lines) begin
          v = int'($urandom_range(0, 523));
          if (v == FLINE) v = FLINE + 1;
          vCount = 10'(v);
        end else begin
          vCount = 10'(FLINE);
        end
      end
    end
    @(negedge clk); rst = 1'b0; vCount = 10'd0;
    @(negedge clk);
    checkEn = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", comparisons, failures);
    $finish;
  end

endmodule
